// File: rtl/quad_step_gen.sv
`timescale 1ns / 1ps
// Quadrature step generator: turns right/left step pulses into full A/B detent cycles.
// Optional abort input and logic are enabled by defining QSG_ABORT_EN.
module quad_step_gen #(
  parameter int unsigned PHASE_CYCLES = 240000,
  parameter int unsigned PEND_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_right,
  input  logic                     step_left,
`ifdef QSG_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     A,
  output logic                     B,
  output logic                     busy,
  output logic signed [PEND_W-1:0] pending,
  output logic                     done,
  output logic                     drop
);

  localparam int unsigned CntW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PHASE_CYCLES - 1);
  // Two guard bits so the unsaturated sum can be range-checked without wrapping.
  localparam int unsigned SumW = PEND_W + 2;
  localparam logic signed [SumW-1:0] PendMax = SumW'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [SumW-1:0] PendMin = ~PendMax;

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StPh4} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      dir_q, dir_d;  // 1 = right
  logic                      a_q, a_d, b_q, b_d;
  logic signed [PEND_W-1:0]  pending_q, pending_d;
  logic                      drop_q, drop_d;
  logic                      start_r, start_l, phase_end;
  logic signed [SumW-1:0]    pend_ext, adj, req, base, full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      a_q       <= 1'b1;
      b_q       <= 1'b1;
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    a_d       = a_q;
    b_d       = b_q;
    start_r   = 1'b0;
    start_l   = 1'b0;
    phase_end = (cnt_q == CntMax);
    unique case (state_q)
      StIdle: begin
        start_r = !pending_q[PEND_W-1] && (pending_q != '0);
        start_l = pending_q[PEND_W-1];
        if (start_r || start_l) begin
          state_d    = StPh1;
          cnt_d      = '0;
          dir_d      = start_r;
          {a_d, b_d} = start_r ? 2'b01 : 2'b10;
        end
      end
      StPh1: begin
        cnt_d = cnt_q + 1'b1;
        if (phase_end) begin
          state_d    = StPh2;
          cnt_d      = '0;
          {a_d, b_d} = 2'b00;
        end
      end
      StPh2: begin
        cnt_d = cnt_q + 1'b1;
        if (phase_end) begin
          state_d    = StPh3;
          cnt_d      = '0;
          {a_d, b_d} = dir_q ? 2'b10 : 2'b01;
        end
      end
      StPh3: begin
        cnt_d = cnt_q + 1'b1;
        if (phase_end) begin
          state_d    = StPh4;
          cnt_d      = '0;
          {a_d, b_d} = 2'b11;
        end
      end
      StPh4: begin
        cnt_d = cnt_q + 1'b1;
        if (phase_end) begin
          state_d    = StIdle;
          cnt_d      = '0;
          {a_d, b_d} = 2'b11;
        end
      end
      default: begin
        state_d    = StIdle;
        cnt_d      = '0;
        {a_d, b_d} = 2'b11;
      end
    endcase
  end

  // Start adjustment always applies; only the request part is dropped on saturation.
  always_comb begin
    pend_ext = {{2{pending_q[PEND_W-1]}}, pending_q};
    adj      = '0;
    if (start_r) begin
      adj = SumW'(1);
    end else if (start_l) begin
      adj = '1;
    end
    req = '0;
    if (step_right && !step_left) begin
      req = SumW'(1);
    end else if (step_left && !step_right) begin
      req = '1;
    end
    base      = pend_ext - adj;
    full      = base + req;
    pending_d = full[PEND_W-1:0];
    drop_d    = 1'b0;
    if ((full > PendMax) || (full < PendMin)) begin
      pending_d = base[PEND_W-1:0];
      drop_d    = 1'b1;
    end
`ifdef QSG_ABORT_EN
    if (abort) begin
      pending_d = '0;
      drop_d    = 1'b0;
    end
`endif
  end

  assign A       = a_q;
  assign B       = b_q;
  assign busy    = (state_q != StIdle);
  assign pending = pending_q;
  assign done    = (state_q == StPh4) && phase_end;
  assign drop    = drop_q;

endmodule
